// File: rtl/snow64_memory_access_read_queue.sv
// snow64_memory_access_read_queue
// Circular queue of up to DEPTH read requests. Requests are issued one at a
// time and in order to the memory bus guard. Each read's data comes back to
// the requester as a one-cycle valid pulse with the request's sequence tag.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_req, in_addr        requester push strobe and aligned address
//   out_busy               queue full, pushes ignored
//   out_count              occupied entries
//   out_req_tag            tag assigned to a push made this cycle
//   out_valid/data/tag     returned read (one-cycle pulse)
//   to_mem_req/addr        command to the memory bus guard
//   from_mem_cmd_accepted  guard took the command
//   from_mem_valid/data    guard read data
module snow64_memory_access_read_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned TAG_WIDTH  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_req,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  output logic                    out_busy,
  output logic [$clog2(DEPTH):0]  out_count,
  output logic [TAG_WIDTH-1:0]    out_req_tag,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    to_mem_req,
  output logic [ADDR_WIDTH-1:0]   to_mem_addr,
  input  logic                    from_mem_cmd_accepted,
  input  logic                    from_mem_valid,
  input  logic [DATA_WIDTH-1:0]   from_mem_data
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_ACCEPT = 2'd1,
    ST_WAIT_DATA   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_mem  [DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic [TAG_WIDTH-1:0] tag_ctr;

  logic push;
  logic pop;
  logic issue;

  // Full comes from the count register only, so a same-cycle pop never frees a slot.
  assign out_busy    = (count == CNT_WIDTH'(DEPTH));
  assign out_count   = count;
  assign out_req_tag = tag_ctr;
  assign push        = in_req && !out_busy;

  // Issue state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Issue next-state: one command outstanding at a time, one idle cycle between.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          state_nxt = ST_WAIT_ACCEPT;
          issue     = 1'b1;
        end
      end
      ST_WAIT_ACCEPT: begin
        if (from_mem_cmd_accepted) begin
          state_nxt = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (from_mem_valid) begin
          state_nxt = ST_IDLE;
          pop       = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Entry storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      tag_mem[wr_ptr]  <= tag_ctr;
    end
  end

  // Pointers, occupancy and tag counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_ctr <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_WIDTH'(1);
        tag_ctr <= tag_ctr + TAG_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered memory command and requester return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_mem_req  <= 1'b0;
      to_mem_addr <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
    end else begin
      to_mem_req <= (state_nxt == ST_WAIT_ACCEPT);
      if (issue) begin
        to_mem_addr <= addr_mem[rd_ptr];
      end
      out_valid <= pop;
      if (pop) begin
        out_data <= from_mem_data;
        out_tag  <= tag_mem[rd_ptr];
      end
    end
  end

endmodule
